// File: rtl/fetch_sequencer.sv
// Fetch-stage PC controller: chooses advance / hold / redirect, and latches redirects that arrive during a stall.
// Optional macro FETCH_SEQ_TRAP_EN enables trap_req; without it trap_req is ignored.
module fetch_sequencer #(
  parameter int                 D_WIDTH   = 32,
  parameter logic [D_WIDTH-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [D_WIDTH-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               stall_f,
  input  logic               br_taken_e,
  input  logic [D_WIDTH-1:0] br_target_e,
  input  logic               jalr_e,
  input  logic [D_WIDTH-1:0] jalr_target_e,
  input  logic               trap_req,
  output logic               pc_en,
  output logic               redirect_valid,
  output logic [D_WIDTH-1:0] redirect_pc,
  output logic               flush_d,
  output logic               flush_e,
  output logic               pending_o
);

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    BOOT     = 2'd1,
    RUN      = 2'd2,
    PENDING  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [D_WIDTH-1:0] pendPc_q, pendPc_d;

  logic               trapReq;
  logic [D_WIDTH-1:0] trapVec;
  logic               evtValid;
  logic [D_WIDTH-1:0] evtTarget;

`ifdef FETCH_SEQ_TRAP_EN
  assign trapReq = trap_req;
  assign trapVec = TRAP_VEC;
`else
  logic unusedTrap;
  assign trapReq    = 1'b0;
  assign trapVec    = '0;
  assign unusedTrap = ^{trap_req, TRAP_VEC};
`endif

  // Fixed priority trap > jalr > branch; jump targets lose bit 0.
  always_comb begin
    evtValid  = trapReq | jalr_e | br_taken_e;
    evtTarget = {br_target_e[D_WIDTH-1:1], 1'b0};
    if (trapReq) begin
      evtTarget = trapVec;
    end else if (jalr_e) begin
      evtTarget = {jalr_target_e[D_WIDTH-1:1], 1'b0};
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= RST_HOLD;
      pendPc_q <= '0;
    end else begin
      state_q  <= state_d;
      pendPc_q <= pendPc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pendPc_d       = pendPc_q;
    pc_en          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    flush_d        = 1'b0;
    flush_e        = 1'b0;
    pending_o      = 1'b0;

    unique case (state_q)
      RST_HOLD: begin
        state_d = BOOT;
      end

      BOOT: begin
        pc_en          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = RESET_VEC;
        flush_d        = 1'b1;
        flush_e        = 1'b1;
        state_d        = RUN;
      end

      RUN: begin
        if (evtValid) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          if (!stall_f) begin
            pc_en          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = evtTarget;
          end else begin
            pendPc_d = evtTarget;
            state_d  = PENDING;
          end
        end else begin
          pc_en = !stall_f;
        end
      end

      // Branches and JALRs seen here are wrong-path and dropped; only a trap can replace the latched target.
      PENDING: begin
        pending_o = 1'b1;
        if (trapReq) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          if (stall_f) begin
            pendPc_d = trapVec;
          end else begin
            pc_en          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = trapVec;
            state_d        = RUN;
          end
        end else if (!stall_f) begin
          pc_en          = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = pendPc_q;
          flush_d        = 1'b1;
          state_d        = RUN;
        end
      end

      default: begin
        state_d = RST_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected output vectors are queued as stimulus is driven and compared mid-cycle.
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        br_taken_e;
  logic [31:0] br_target_e;
  logic        jalr_e;
  logic [31:0] jalr_target_e;
  logic        trap_req;
  logic        pc_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_d;
  logic        flush_e;
  logic        pending_o;

  int checkCount = 0;
  int errorCount = 0;

  logic [36:0] expQ[$];
  string       tagQ[$];

  fetch_sequencer #(
    .D_WIDTH  (32),
    .RESET_VEC(32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .CLK           (CLK),
    .rst           (rst),
    .stall_f       (stall_f),
    .br_taken_e    (br_taken_e),
    .br_target_e   (br_target_e),
    .jalr_e        (jalr_e),
    .jalr_target_e (jalr_target_e),
    .trap_req      (trap_req),
    .pc_en         (pc_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flush_d       (flush_d),
    .flush_e       (flush_e),
    .pending_o     (pending_o)
  );

  always #5 CLK = ~CLK;

`ifdef FETCH_SEQ_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  function automatic logic [36:0] mk(input logic pe, input logic rv, input logic [31:0] pc,
                                     input logic fd, input logic fe, input logic pend);
    return {pe, rv, pc, fd, fe, pend};
  endfunction

  task automatic checkOutput(input string tag, input logic [36:0] actual, input logic [36:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got pe=%b rv=%b pc=%h fd=%b fe=%b pend=%b, want pe=%b rv=%b pc=%h fd=%b fe=%b pend=%b",
               tag, actual[36], actual[35], actual[34:3], actual[2], actual[1], actual[0],
               expected[36], expected[35], expected[34:3], expected[2], expected[1], expected[0]);
    end
  endtask

  task automatic sampleAndCheck();
    logic [36:0] observed;
    observed = {pc_en, redirect_valid, redirect_pc, flush_d, flush_e, pending_o};
    if (expQ.size() == 0) begin
      checkOutput("scoreboard-empty", observed, ~observed);
    end else begin
      checkOutput(tagQ.pop_front(), observed, expQ.pop_front());
    end
  endtask

  // Drive one cycle's inputs just after the edge, queue its expectation, compare at the falling edge.
  task automatic applyStimulus(input string tag, input logic st, input logic br, input logic [31:0] brT,
                               input logic jr, input logic [31:0] jrT, input logic tr,
                               input logic [36:0] expected);
    @(posedge CLK);
    #1;
    stall_f       = st;
    br_taken_e    = br;
    br_target_e   = brT;
    jalr_e        = jr;
    jalr_target_e = jrT;
    trap_req      = tr;
    expQ.push_back(expected);
    tagQ.push_back(tag);
    @(negedge CLK);
    sampleAndCheck();
  endtask

  initial begin
    rst           = 1'b1;
    stall_f       = 1'b0;
    br_taken_e    = 1'b0;
    br_target_e   = '0;
    jalr_e        = 1'b0;
    jalr_target_e = '0;
    trap_req      = 1'b0;

    repeat (2) @(negedge CLK);
    expQ.push_back(mk(0, 0, 32'h0, 0, 0, 0));
    tagQ.push_back("reset-hold");
    sampleAndCheck();
    rst = 1'b0;

    applyStimulus("boot",       1, 0, 0, 0, 0, 0, mk(1, 1, 32'h0, 1, 1, 0));
    applyStimulus("run-idle",   0, 0, 0, 0, 0, 0, mk(1, 0, 32'h0, 0, 0, 0));
    applyStimulus("run-stall",  1, 0, 0, 0, 0, 0, mk(0, 0, 32'h0, 0, 0, 0));
    applyStimulus("br-unstall", 0, 1, 32'h45, 0, 0, 0, mk(1, 1, 32'h44, 1, 1, 0));
    applyStimulus("jalr-mask",  0, 0, 0, 1, 32'h333, 0, mk(1, 1, 32'h332, 1, 1, 0));

    applyStimulus("jalr-stall-evt", 1, 0, 0, 1, 32'h200, 0, mk(0, 0, 32'h0, 1, 1, 0));
    applyStimulus("jalr-stall-2",   1, 1, 32'h999, 0, 0, 0, mk(0, 0, 32'h0, 0, 0, 1));
    applyStimulus("jalr-stall-3",   1, 0, 0, 1, 32'h777, 0, mk(0, 0, 32'h0, 0, 0, 1));
    applyStimulus("jalr-issue",     0, 0, 0, 0, 0, 0, mk(1, 1, 32'h200, 1, 0, 1));
    applyStimulus("after-issue",    0, 0, 0, 0, 0, 0, mk(1, 0, 32'h0, 0, 0, 0));

    applyStimulus("priority-all", 0, 1, 32'h400, 1, 32'h300, 1,
                  TRAP_ON ? mk(1, 1, 32'h100, 1, 1, 0) : mk(1, 1, 32'h300, 1, 1, 0));
    applyStimulus("trap-alone", 0, 0, 0, 0, 0, 1,
                  TRAP_ON ? mk(1, 1, 32'h100, 1, 1, 0) : mk(1, 0, 32'h0, 0, 0, 0));

    applyStimulus("br-latch",     1, 1, 32'h81, 0, 0, 0, mk(0, 0, 32'h0, 1, 1, 0));
    applyStimulus("trap-pending", 1, 0, 0, 0, 0, 1,
                  TRAP_ON ? mk(0, 0, 32'h0, 1, 1, 1) : mk(0, 0, 32'h0, 0, 0, 1));
    applyStimulus("trap-pend-issue", 0, 0, 0, 0, 0, 0,
                  TRAP_ON ? mk(1, 1, 32'h100, 1, 0, 1) : mk(1, 1, 32'h80, 1, 0, 1));

    applyStimulus("br-latch-2",   1, 1, 32'h90, 0, 0, 0, mk(0, 0, 32'h0, 1, 1, 0));
    applyStimulus("trap-pend-direct", 0, 0, 0, 0, 0, 1,
                  TRAP_ON ? mk(1, 1, 32'h100, 1, 1, 1) : mk(1, 1, 32'h90, 1, 0, 1));
    applyStimulus("run-again",    0, 0, 0, 0, 0, 0, mk(1, 0, 32'h0, 0, 0, 0));

    applyStimulus("br-latch-3",   1, 1, 32'hA4, 0, 0, 0, mk(0, 0, 32'h0, 1, 1, 0));
    applyStimulus("pending-hold", 1, 0, 0, 0, 0, 0, mk(0, 0, 32'h0, 0, 0, 1));
    #2;
    rst = 1'b1;
    #1;
    expQ.push_back(mk(0, 0, 32'h0, 0, 0, 0));
    tagQ.push_back("reset-in-pending");
    sampleAndCheck();
    stall_f = 1'b0;
    @(negedge CLK);
    rst = 1'b0;

    applyStimulus("reboot",        1, 0, 0, 0, 0, 0, mk(1, 1, 32'h0, 1, 1, 0));
    applyStimulus("reboot-run",    0, 0, 0, 0, 0, 0, mk(1, 0, 32'h0, 0, 0, 0));
    applyStimulus("reboot-run-2",  0, 0, 0, 0, 0, 0, mk(1, 0, 32'h0, 0, 0, 0));

    if (expQ.size() != 0) begin
      checkOutput("scoreboard-leftover", 37'(expQ.size()), 37'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
